// File: rtl/dma_rw_sequencer_if.sv
// Control/status bundle between the DMA channel controller and the bus-cycle sequencer.
// The tri-state bus pins (IORD/IOWR/A) stay as plain inout ports on the sequencer.
interface dma_rw_sequencer_if #(
    parameter int AW = 4,
    parameter int CW = 4
);
    logic          MASTER;
    logic          START;
    logic [1:0]    MODE;
    logic          DEC;
    logic          AUTOINIT;
    logic [AW-1:0] BASE_ADDR;
    logic [CW-1:0] BASE_CNT;
    logic          READY;
    logic          BUSY;
    logic          TC;
    logic [AW-1:0] CUR_ADDR;
    logic [CW-1:0] CUR_CNT;
    logic          S_RD;
    logic          S_WR;
    logic [AW-1:0] S_A;

    modport master (
        output MASTER, START, MODE, DEC, AUTOINIT, BASE_ADDR, BASE_CNT, READY,
        input  BUSY, TC, CUR_ADDR, CUR_CNT, S_RD, S_WR, S_A
    );
    modport slave (
        input  MASTER, START, MODE, DEC, AUTOINIT, BASE_ADDR, BASE_CNT, READY,
        output BUSY, TC, CUR_ADDR, CUR_CNT, S_RD, S_WR, S_A
    );
endinterface

// File: rtl/dma_rw_sequencer.sv
// DMA bus-cycle sequencer: runs blocks of IORD/IOWR cycles as bus master and
// captures CPU-driven IORD/IOWR/A for register decode while the bus is released.
module dma_rw_sequencer #(
    parameter int AW = 4,
    parameter int CW = 4
) (
    input  logic                CLK,
    input  logic                RST,
    dma_rw_sequencer_if.slave   bus,
    inout  wire                 IORD,
    inout  wire                 IOWR,
    inout  wire  [AW-1:0]       A
);
    typedef enum logic [1:0] {IDLE, S_ADDR, S_STB, S_UPD} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_iord, r_iowr, r_busy, r_tc;
    logic          w_rd_nxt, w_wr_nxt, w_busy_nxt, w_tc_nxt;
    logic          r_srd, r_swr;
    logic [AW-1:0] r_sa;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.START) w_next = S_ADDR;
            S_ADDR:  if (bus.MASTER) w_next = S_STB;
            // Losing the grant mid-strobe abandons the transfer; it is retried from S_ADDR.
            S_STB:   if (!bus.MASTER)   w_next = S_ADDR;
                     else if (bus.READY) w_next = S_UPD;
            S_UPD:   w_next = (r_cnt == '0 && !bus.AUTOINIT) ? IDLE : S_ADDR;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt = r_addr;
        w_cnt_nxt  = r_cnt;
        w_rd_nxt   = (w_next == S_STB) && (bus.MODE == 2'b10);
        w_wr_nxt   = (w_next == S_STB) && (bus.MODE == 2'b01);
        w_busy_nxt = (w_next != IDLE);
        // TC is registered on entry to S_UPD so it is high exactly during the final S_UPD.
        w_tc_nxt   = (r_state == S_STB) && (w_next == S_UPD) && (r_cnt == '0);
        if (r_state == IDLE && bus.START) begin
            w_addr_nxt = bus.BASE_ADDR;
            w_cnt_nxt  = bus.BASE_CNT;
        end else if (r_state == S_UPD) begin
            w_addr_nxt = bus.DEC ? r_addr - AW'(1) : r_addr + AW'(1);
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - CW'(1);
            end else if (bus.AUTOINIT) begin
                w_addr_nxt = bus.BASE_ADDR;
                w_cnt_nxt  = bus.BASE_CNT;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_iord <= 1'b0;
            r_iowr <= 1'b0;
            r_busy <= 1'b0;
            r_tc   <= 1'b0;
            r_srd  <= 1'b0;
            r_swr  <= 1'b0;
            r_sa   <= '0;
        end else begin
            r_addr <= w_addr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_iord <= w_rd_nxt;
            r_iowr <= w_wr_nxt;
            r_busy <= w_busy_nxt;
            r_tc   <= w_tc_nxt;
            if (!bus.MASTER) begin
                r_srd <= IORD;
                r_swr <= IOWR;
                r_sa  <= A;
            end
        end
    end

    assign IORD = bus.MASTER ? r_iord : 1'bz;
    assign IOWR = bus.MASTER ? r_iowr : 1'bz;
    assign A    = bus.MASTER ? r_addr : {AW{1'bz}};

    assign bus.BUSY     = r_busy;
    assign bus.TC       = r_tc;
    assign bus.CUR_ADDR = r_addr;
    assign bus.CUR_CNT  = r_cnt;
    assign bus.S_RD     = r_srd;
    assign bus.S_WR     = r_swr;
    assign bus.S_A      = r_sa;
endmodule

// File: tb/tb_dma_rw_sequencer.sv
// Directed bench for dma_rw_sequencer: a per-cycle vector table for a plain read block,
// plus hand-written sequences for wait states, auto-init, grant loss, slave capture and reset.
module tb_dma_rw_sequencer;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dma_rw_sequencer_if #(.AW(4), .CW(4)) bus ();
    wire       IORD, IOWR;
    wire [3:0] A;

    // Pull-ups make a released bus read as all ones, distinguishable from a driven 0.
    pullup (IORD);
    pullup (IOWR);
    pullup (A[0]);
    pullup (A[1]);
    pullup (A[2]);
    pullup (A[3]);

    logic       tb_drv, tb_rd, tb_wr;
    logic [3:0] tb_a;
    assign IORD = tb_drv ? tb_rd : 1'bz;
    assign IOWR = tb_drv ? tb_wr : 1'bz;
    assign A    = tb_drv ? tb_a  : 4'bzzzz;

    dma_rw_sequencer #(.AW(4), .CW(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .IORD (IORD),
        .IOWR (IOWR),
        .A    (A)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic       start;
        logic       e_busy, e_tc, e_rd;
        logic [3:0] e_a, e_cnt;
    } vec_t;

    function automatic vec_t mk(logic st, logic b, logic tc, logic rd, logic [3:0] a, logic [3:0] c);
        vec_t v;
        v.start = st; v.e_busy = b; v.e_tc = tc; v.e_rd = rd; v.e_a = a; v.e_cnt = c;
        return v;
    endfunction

    vec_t vt [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int wr5, wr4, both, tcn, tc_off, a_bad, busy_bad, strobes;
        bit done;

        vt[0]  = mk(1, 0, 0, 0, 4'h0, 4'd0);
        vt[1]  = mk(0, 1, 0, 0, 4'hE, 4'd3);
        vt[2]  = mk(0, 1, 0, 1, 4'hE, 4'd3);
        vt[3]  = mk(0, 1, 0, 0, 4'hE, 4'd3);
        vt[4]  = mk(0, 1, 0, 0, 4'hF, 4'd2);
        vt[5]  = mk(0, 1, 0, 1, 4'hF, 4'd2);
        vt[6]  = mk(0, 1, 0, 0, 4'hF, 4'd2);
        vt[7]  = mk(0, 1, 0, 0, 4'h0, 4'd1);
        vt[8]  = mk(0, 1, 0, 1, 4'h0, 4'd1);
        vt[9]  = mk(0, 1, 0, 0, 4'h0, 4'd1);
        vt[10] = mk(0, 1, 0, 0, 4'h1, 4'd0);
        vt[11] = mk(0, 1, 0, 1, 4'h1, 4'd0);
        vt[12] = mk(0, 1, 1, 0, 4'h1, 4'd0);
        vt[13] = mk(0, 0, 0, 0, 4'h2, 4'd0);

        RST = 1'b1;
        tb_drv = 1'b0; tb_rd = 1'b0; tb_wr = 1'b0; tb_a = 4'h0;
        bus.MASTER = 1'b1; bus.START = 1'b0; bus.MODE = 2'b10; bus.DEC = 1'b0;
        bus.AUTOINIT = 1'b0; bus.READY = 1'b1; bus.BASE_ADDR = 4'hE; bus.BASE_CNT = 4'd3;

        #3;
        chk("reset IORD", IORD, 0);
        chk("reset IOWR", IOWR, 0);
        chk("reset A", A, 0);
        chk("reset BUSY", bus.BUSY, 0);
        chk("reset TC", bus.TC, 0);
        chk("reset CUR_CNT", bus.CUR_CNT, 0);
        chk("reset S_A", bus.S_A, 0);
        bus.MASTER = 1'b0;
        #1;
        chk("released IORD", IORD, 1);
        chk("released IOWR", IOWR, 1);
        chk("released A", A, 4'hF);
        bus.MASTER = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        next_cyc();

        // Read block E..1, incrementing with wrap, one row per cycle.
        for (int i = 0; i < 14; i++) begin
            bus.START = vt[i].start;
            @(negedge CLK);
            chk($sformatf("tbl[%0d] BUSY", i), bus.BUSY, vt[i].e_busy);
            chk($sformatf("tbl[%0d] TC", i), bus.TC, vt[i].e_tc);
            chk($sformatf("tbl[%0d] IORD", i), IORD, vt[i].e_rd);
            chk($sformatf("tbl[%0d] IOWR", i), IOWR, 0);
            chk($sformatf("tbl[%0d] A", i), A, vt[i].e_a);
            chk($sformatf("tbl[%0d] CUR_CNT", i), bus.CUR_CNT, vt[i].e_cnt);
            next_cyc();
        end

        // Decrementing write block with two wait states in the first strobe.
        bus.BASE_ADDR = 4'h5; bus.BASE_CNT = 4'd1; bus.MODE = 2'b01; bus.DEC = 1'b1;
        bus.START = 1'b1;
        next_cyc();
        bus.START = 1'b0;
        wr5 = 0; wr4 = 0; both = 0; tcn = 0;
        for (int c = 1; c <= 10; c++) begin
            bus.READY = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            @(negedge CLK);
            if (IOWR === 1'b1 && A === 4'h5) wr5++;
            if (IOWR === 1'b1 && A === 4'h4) wr4++;
            if (IOWR === 1'b1 && IORD === 1'b1) both++;
            if (bus.TC === 1'b1) tcn++;
            next_cyc();
        end
        bus.READY = 1'b1;
        chk("wait IOWR cycles at 5", wr5, 3);
        chk("wait IOWR cycles at 4", wr4, 1);
        chk("wait IORD with IOWR", both, 0);
        chk("wait TC pulses", tcn, 1);
        chk("wait BUSY end", bus.BUSY, 0);
        chk("wait CUR_ADDR end", bus.CUR_ADDR, 4'h3);

        // Auto-initialise with a single-transfer block.
        bus.BASE_ADDR = 4'h3; bus.BASE_CNT = 4'd0; bus.MODE = 2'b10; bus.DEC = 1'b0;
        bus.AUTOINIT = 1'b1; bus.START = 1'b1;
        next_cyc();
        bus.START = 1'b0;
        tcn = 0; tc_off = 0; a_bad = 0; busy_bad = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (bus.TC === 1'b1) begin
                tcn++;
                if (c % 3 != 0) tc_off++;
            end
            if (A !== 4'h3) a_bad++;
            if (bus.BUSY !== 1'b1) busy_bad++;
            next_cyc();
        end
        chk("autoinit TC pulses", tcn, 4);
        chk("autoinit TC spacing", tc_off, 0);
        chk("autoinit A not 3", a_bad, 0);
        chk("autoinit BUSY drop", busy_bad, 0);
        bus.AUTOINIT = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge CLK);
            if (bus.BUSY === 1'b0) done = 1'b1;
            next_cyc();
        end
        chk("autoinit stop within budget", done, 1);

        // Grant lost during the second strobe; START mid-block must not reload.
        bus.BASE_ADDR = 4'h8; bus.BASE_CNT = 4'd2; bus.START = 1'b1;
        next_cyc();
        strobes = 0; tcn = 0;
        for (int c = 1; c <= 13; c++) begin
            bus.START     = (c == 4);
            bus.BASE_ADDR = (c == 4) ? 4'h2 : 4'h8;
            bus.BASE_CNT  = (c == 4) ? 4'd7 : 4'd2;
            bus.MASTER    = (c != 5);
            @(negedge CLK);
            if (bus.MASTER && IORD === 1'b1) begin
                chk($sformatf("drop strobe %0d addr", strobes), A, 4'h8 + strobes);
                strobes++;
            end
            if (c == 5) begin
                chk("drop A released", A, 4'hF);
                chk("drop IOWR released", IOWR, 1);
            end
            if (c == 6) begin
                chk("drop retry A", A, 4'h9);
                chk("drop retry CUR_CNT", bus.CUR_CNT, 4'd1);
                chk("drop retry IORD setup", IORD, 0);
            end
            if (bus.TC === 1'b1) tcn++;
            next_cyc();
        end
        bus.START = 1'b0; bus.MASTER = 1'b1;
        chk("drop completed strobes", strobes, 3);
        chk("drop TC pulses", tcn, 1);
        chk("drop BUSY end", bus.BUSY, 0);
        chk("drop CUR_ADDR end", bus.CUR_ADDR, 4'hB);

        // Slave capture of CPU-driven cycles, then hold once granted.
        bus.MASTER = 1'b0;
        tb_drv = 1'b1; tb_rd = 1'b1; tb_wr = 1'b0; tb_a = 4'h9;
        next_cyc();
        chk("slave S_RD", bus.S_RD, 1);
        chk("slave S_WR", bus.S_WR, 0);
        chk("slave S_A", bus.S_A, 4'h9);
        tb_drv = 1'b0;
        bus.MASTER = 1'b1;
        tb_a = 4'h5;
        next_cyc();
        chk("slave hold S_A", bus.S_A, 4'h9);
        chk("slave hold S_RD", bus.S_RD, 1);

        // Asynchronous reset in the middle of a write strobe.
        bus.BASE_ADDR = 4'h6; bus.BASE_CNT = 4'd3; bus.MODE = 2'b01; bus.START = 1'b1;
        next_cyc();
        bus.START = 1'b0;
        next_cyc();
        chk("midrst pre IOWR", IOWR, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst BUSY", bus.BUSY, 0);
        chk("midrst IOWR", IOWR, 0);
        chk("midrst A", A, 0);
        chk("midrst TC", bus.TC, 0);
        chk("midrst CUR_CNT", bus.CUR_CNT, 0);
        @(negedge CLK);
        RST = 1'b0;
        next_cyc();
        chk("midrst stays idle", bus.BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
